// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter for two client ports sharing one I2C master.
// Launches the winning command, waits for completion or watchdog, then pulses ACK/ERR.
module i2c_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic        RNW0,
  input  logic        RNW1,
  input  logic        TWOBYTE0,
  input  logic        TWOBYTE1,
  input  logic [6:0]  ADDR0,
  input  logic [6:0]  ADDR1,
  input  logic [15:0] WDATA0,
  input  logic [15:0] WDATA1,
  output logic        ACK0,
  output logic        ACK1,
  output logic        ERR0,
  output logic        ERR1,
  output logic [15:0] RDATA,
  output logic        BUSY,
  output logic        GNT_ID,
  output logic        START_STB,
  output logic        RNW,
  output logic        TWOBYTE,
  output logic [6:0]  I2C_ADDR,
  output logic [15:0] WR_DATA,
  input  logic        MST_DONE,
  input  logic [15:0] MST_RD_DATA
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_LAUNCH = 4'b0010,
    ST_WAIT   = 4'b0100,
    ST_DONE   = 4'b1000
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        last;
  logic        err_flag;
  logic [15:0] cnt;
  logic        win;

  // On a tie the port that did not own the previous grant wins.
  always_comb begin
    win = REQ1;
    if (REQ0 && REQ1) win = ~last;
  end

  // ERR is qualified by the registered ACK so it can only ever pulse with it.
  assign ERR0 = ACK0 & err_flag;
  assign ERR1 = ACK1 & err_flag;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= ST_IDLE;
      last      <= 1'b1;
      err_flag  <= 1'b0;
      cnt       <= '0;
      START_STB <= 1'b0;
      ACK0      <= 1'b0;
      ACK1      <= 1'b0;
      RDATA     <= '0;
      BUSY      <= 1'b0;
      GNT_ID    <= 1'b0;
      RNW       <= 1'b0;
      TWOBYTE   <= 1'b0;
      I2C_ADDR  <= '0;
      WR_DATA   <= '0;
    end else begin
      START_STB <= 1'b0;
      ACK0      <= 1'b0;
      ACK1      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (REQ0 || REQ1) begin
            GNT_ID    <= win;
            RNW       <= win ? RNW1     : RNW0;
            TWOBYTE   <= win ? TWOBYTE1 : TWOBYTE0;
            I2C_ADDR  <= win ? ADDR1    : ADDR0;
            WR_DATA   <= win ? WDATA1   : WDATA0;
            START_STB <= 1'b1;
            BUSY      <= 1'b1;
            state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt + 16'd1;
          // Completion takes priority over a watchdog expiry in the same cycle.
          if (MST_DONE) begin
            if (RNW) RDATA <= MST_RD_DATA;
            err_flag <= 1'b0;
            ACK0     <= ~GNT_ID;
            ACK1     <= GNT_ID;
            state    <= ST_DONE;
          end else if (cnt == TO_LAST) begin
            err_flag <= 1'b1;
            ACK0     <= ~GNT_ID;
            ACK1     <= GNT_ID;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          last  <= GNT_ID;
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
